gcd_dispatch: RTL
=================

// Module: gcd_dispatch
// PURPOSE
//  Upstream feeder and downstream collector for the gcd engine in the temperature-averaging datapath.
//  Buffers operand pairs from the producer in a small FIFO and issues them one at a time to the engine.
//  Holds each pair stable for the engine's full run and returns each result on a valid/ready output port.
//  Results leave in issue order; only one request is in flight at any time.
// PARAMETERS
//  WIDTH   32  operand/result width; must match the gcd engine (32)
//  DEPTH   4   request FIFO entries; power of two, >= 2
// PORTS
//  clk          in   1      sole clock, rising edge
//  reset        in   1      synchronous, active-high reset
//  in_valid     in   1      producer offers {in_a,in_b}
//  in_ready     out  1      FIFO can accept (= !full)
//  in_a         in   WIDTH  operand a
//  in_b         in   WIDTH  operand b
//  gcd_a        out  WIDTH  to engine a_in; stable from start cycle until done seen
//  gcd_b        out  WIDTH  to engine b_in; stable from start cycle until done seen
//  gcd_start    out  1      one-cycle start pulse to engine
//  gcd_result   in   WIDTH  engine result, sampled when gcd_done=1
//  gcd_done     in   1      engine done
//  out_valid    out  1      out_result valid; held until out_ready
//  out_ready    in   1      consumer accepts
//  out_result   out  WIDTH  gcd of the oldest issued pair
//  busy         out  1      FSM not in S_IDLE, or FIFO not empty
//  err_done     out  1      sticky: gcd_done seen outside S_WAIT; cleared only by reset
// BEHAVIOUR
//  Reset (synchronous, highest priority): flush FIFO; FSM to S_IDLE.
//   All outputs 0, except in_ready=1; gcd_a, gcd_b and out_result are 0.
//  Reset mid-run: any in-flight request is discarded; its late gcd_done is ignored and does not set err_done.
//   The engine is reset by the same top-level reset network.
//  FIFO push: in_valid && in_ready.
//   Full: in_ready=0, including in the cycle a pop occurs; no same-cycle push-through when full.
//   Push and pop in the same cycle are allowed when not full.
//  FSM:
//   S_IDLE:  if FIFO not empty, pop the head into gcd_a/gcd_b and go to S_START; else stay.
//   S_START: gcd_start=1 for exactly this cycle; go to S_WAIT.
//   S_WAIT:  gcd_start=0, operands held. On gcd_done=1, capture gcd_result into out_result and go to S_OUT.
//            No timeout.
//   S_OUT:   out_valid=1, out_result held. On out_ready, go to S_IDLE.
//  Latency: pop-to-start is 1 cycle; done-to-out_valid is 1 cycle.
//   Next pop occurs in the cycle after out_ready handshake (S_IDLE).
//  gcd_done is level-sensitive, but only the first cycle in S_WAIT counts; out_result is WIDTH bits, unmodified.
//  Equal operands (a==b) go through the engine normally (result = a).
// CONFIGURATION
//  GCD_DISPATCH_ZERO_BYPASS_EN
//   Defined: in S_IDLE, a popped pair with a==0 or b==0 skips the engine.
//    out_result = a|b (gcd(x,0)=x, gcd(0,0)=0); go directly to S_OUT; no gcd_start.
//   Undefined: zero operands are issued to the engine like any pair.
//    Producer must not send them; the engine does not terminate on a zero operand.
// STRUCTURE
//  Package gcd_pkg: WIDTH_DEF=32, enum logic[3:0] dispatch_state_t {S_IDLE,S_START,S_WAIT,S_OUT} (one-hot).
//   Also a typedef struct packed {a,b} gcd_pair_t.
//  Sub-module gcd_req_fifo: DEPTH x gcd_pair_t, wrap-around read/write pointers with extra bit for full/empty.
//   Signals: push/pop/full/empty.
//  gcd_dispatch: FSM, operand/result registers, error flag, optional bypass.
// TESTING
//  Push (48,18) -> one gcd_start pulse, gcd_a=48/gcd_b=18 held through done; out_result=6.
//  Push (21,6),(35,14),(9,9),(17,5), out_ready=1 -> outputs 3,7,9,1 in order.
//   Exactly 4 start pulses.
//  Fill DEPTH=4 with out_ready=0 -> in_ready=0 after 4th push (1 popped, so 5th accepted first).
//   No pair lost; release -> all results in order.
//  Assert reset during S_WAIT of (100,75), then push (12,8) -> stale done ignored.
//   err_done=0; out_result=4.
//  Pulse gcd_done in S_IDLE -> err_done=1 and stays 1 until reset.
//  With GCD_DISPATCH_ZERO_BYPASS_EN: push (0,27) -> out_result=27, no gcd_start.
//   Without the macro: confirm gcd_start=1 on the same push.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared types for the gcd dispatcher: dispatcher state encoding and the operand pair
// carried through the request FIFO.
package gcd_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [3:0] {
    S_IDLE  = 4'b0001,
    S_START = 4'b0010,
    S_WAIT  = 4'b0100,
    S_OUT   = 4'b1000
  } dispatch_state_t;

  typedef struct packed {
    logic [WIDTH_DEF-1:0] a;
    logic [WIDTH_DEF-1:0] b;
  } gcd_pair_t;

  // gcd(x,0)=x and gcd(0,0)=0, so a pair with a zero operand resolves to a|b.
  function automatic logic is_zero_pair(input gcd_pair_t p);
    return (p.a == '0) || (p.b == '0);
  endfunction

endpackage

// File: rtl/gcd_dispatch_if.sv
// Producer, engine and consumer signals of the gcd dispatcher. The slave modport is the
// dispatcher's view; the master modport is the view of everything around it.
interface gcd_dispatch_if #(
  parameter int WIDTH = gcd_pkg::WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [WIDTH-1:0] gcd_a;
  logic [WIDTH-1:0] gcd_b;
  logic             gcd_start;
  logic [WIDTH-1:0] gcd_result;
  logic             gcd_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             busy;
  logic             err_done;

  modport slave (
    input  in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
    output in_ready, gcd_a, gcd_b, gcd_start, out_valid, out_result, busy, err_done
  );

  modport master (
    output in_valid, in_a, in_b, gcd_result, gcd_done, out_ready,
    input  in_ready, gcd_a, gcd_b, gcd_start, out_valid, out_result, busy, err_done
  );

endinterface

// File: rtl/gcd_req_fifo.sv
// Request FIFO of operand pairs. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module gcd_req_fifo
  import gcd_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  gcd_pair_t din,
  output gcd_pair_t dout,
  output logic      full,
  output logic      empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  gcd_pair_t     mem [DEPTH];
  logic [AW:0]   wptr;
  logic [AW:0]   rptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign empty   = (wptr == rptr);
  // A full FIFO refuses pushes even when a pop happens in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/gcd_dispatch.sv
// Feeds buffered operand pairs to the gcd engine one at a time and returns results in order.
// Optional feature macro: GCD_DISPATCH_ZERO_BYPASS_EN (pairs with a zero operand skip the engine).
module gcd_dispatch
  import gcd_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            reset,
  gcd_dispatch_if.slave   bus
);

  dispatch_state_t  state;
  gcd_pair_t        in_pair;
  gcd_pair_t        head;
  logic             full;
  logic             empty;
  logic             pop;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;
  logic             start;
  logic             valid;
  logic             err;

  assign in_pair = '{a: bus.in_a, b: bus.in_b};
  assign pop     = (state == S_IDLE) && !empty;

  gcd_req_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (bus.in_valid),
    .pop   (pop),
    .din   (in_pair),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign bus.in_ready   = !full;
  assign bus.gcd_a      = op_a;
  assign bus.gcd_b      = op_b;
  assign bus.gcd_start  = start;
  assign bus.out_valid  = valid;
  assign bus.out_result = result;
  assign bus.err_done   = err;
  assign bus.busy       = (state != S_IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      result <= '0;
      start  <= 1'b0;
      valid  <= 1'b0;
      err    <= 1'b0;
    end else begin
      start <= 1'b0;
      // A done outside S_WAIT has no request to belong to.
      if (bus.gcd_done && (state != S_WAIT)) err <= 1'b1;

      unique case (state)
        S_IDLE: begin
          if (!empty) begin
            op_a <= head.a;
            op_b <= head.b;
`ifdef GCD_DISPATCH_ZERO_BYPASS_EN
            if (is_zero_pair(head)) begin
              result <= head.a | head.b;
              valid  <= 1'b1;
              state  <= S_OUT;
            end else begin
              start <= 1'b1;
              state <= S_START;
            end
`else
            start <= 1'b1;
            state <= S_START;
`endif
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (bus.gcd_done) begin
            result <= bus.gcd_result;
            valid  <= 1'b1;
            state  <= S_OUT;
          end
        end
        S_OUT: begin
          if (bus.out_ready) begin
            valid <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
